lattice_bram_arbiter: RTL and testbench

LATTICE_BRAM_ARBITER -- requirements
Module: lattice_bram_arbiter

---
 rtl/lattice_bram_arbiter.sv | 137 +++++++++++++
 tb/tb_lattice_bram_arbiter.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/lattice_bram_arbiter.sv
// Two-requester arbiter in front of nine lattice BRAM banks. The sim engine
// touches all nine neighbour banks per access, and the display reader
// broadcasts one address to every bank. The display has priority, but the
// sim engine is forced through after MAX_STARVE contested cycles. Read
// returns are routed back by a requester tag that travels alongside the
// BRAM read pipeline.
module lattice_bram_arbiter #(
  parameter int unsigned BRAM_DEPTH   = 31570,
  parameter int unsigned READ_LATENCY = 2,
  parameter int unsigned MAX_STARVE   = 8,
  parameter int unsigned ADDR_W       = $clog2(BRAM_DEPTH)
) (
  input  logic                   clk_in,
  input  logic                   rst_in,
  // Simulation engine port
  input  logic                   sim_req_in,
  input  logic                   sim_we_in,
  input  logic [8:0][ADDR_W-1:0] sim_addr_in,
  input  logic [8:0][7:0]        sim_data_in,
  output logic                   sim_grant_out,
  output logic [8:0][7:0]        sim_rdata_out,
  output logic                   sim_rvalid_out,
  // Display reader port
  input  logic                   disp_req_in,
  input  logic [ADDR_W-1:0]      disp_addr_in,
  output logic                   disp_grant_out,
  output logic [8:0][7:0]        disp_rdata_out,
  output logic                   disp_rvalid_out,
  // BRAM bank port
  output logic [8:0][ADDR_W-1:0] bram_addr_out,
  output logic [8:0][7:0]        bram_data_out,
  output logic                   bram_we_out,
  input  logic [8:0][7:0]        bram_data_in,
  output logic                   addr_err_out
);

  localparam int unsigned StarveW = $clog2(MAX_STARVE + 1);
  localparam int unsigned Stages  = READ_LATENCY + 1;

  logic [StarveW-1:0]     starve_cnt_q, starve_cnt_d;
  logic [8:0][ADDR_W-1:0] addr_q, addr_d;
  logic [8:0][7:0]        data_q, data_d;
  logic                   we_q, we_d;
  logic                   err_q, err_d;
  logic [Stages-1:0]      sim_tag_q, sim_tag_d;
  logic [Stages-1:0]      disp_tag_q, disp_tag_d;

  logic sim_grant, disp_grant;
  logic sim_bad, disp_bad;

  // Grant decision: display wins contention unless the sim engine has starved.
  always_comb begin
    sim_grant  = 1'b0;
    disp_grant = 1'b0;
    if (!rst_in) begin
      if (sim_req_in && (!disp_req_in || starve_cnt_q == StarveW'(MAX_STARVE))) begin
        sim_grant = 1'b1;
      end else if (disp_req_in) begin
        disp_grant = 1'b1;
      end
    end
  end

  // Out-of-range detection; a single bad sim bank poisons the whole access.
  always_comb begin
    sim_bad = 1'b0;
    for (int b = 0; b < 9; b++) begin
      if (32'(sim_addr_in[b]) >= BRAM_DEPTH) sim_bad = 1'b1;
    end
    disp_bad = (32'(disp_addr_in) >= BRAM_DEPTH);
  end

  // Next-state for the starve counter, BRAM drive registers and tag pipes.
  always_comb begin
    starve_cnt_d = starve_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    we_d         = 1'b0;
    err_d        = 1'b0;
    sim_tag_d    = sim_tag_q << 1;
    disp_tag_d   = disp_tag_q << 1;

    if (sim_grant) begin
      starve_cnt_d = '0;
    end else if (sim_req_in && starve_cnt_q != StarveW'(MAX_STARVE)) begin
      starve_cnt_d = starve_cnt_q + StarveW'(1);
    end

    if (sim_grant) begin
      addr_d       = sim_addr_in;
      data_d       = sim_data_in;
      we_d         = sim_we_in && !sim_bad;
      err_d        = sim_bad;
      sim_tag_d[0] = !sim_we_in && !sim_bad;
    end else if (disp_grant) begin
      addr_d        = {9{disp_addr_in}};
      err_d         = disp_bad;
      disp_tag_d[0] = !disp_bad;
    end
  end

  // State registers; reset also flushes any reads still in flight.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      starve_cnt_q <= '0;
      addr_q       <= '0;
      data_q       <= '0;
      we_q         <= 1'b0;
      err_q        <= 1'b0;
      sim_tag_q    <= '0;
      disp_tag_q   <= '0;
    end else begin
      starve_cnt_q <= starve_cnt_d;
      addr_q       <= addr_d;
      data_q       <= data_d;
      we_q         <= we_d;
      err_q        <= err_d;
      sim_tag_q    <= sim_tag_d;
      disp_tag_q   <= disp_tag_d;
    end
  end

  // Output mapping; read data is shared, only the tag decides who sees valid.
  always_comb begin
    sim_grant_out   = sim_grant;
    disp_grant_out  = disp_grant;
    bram_addr_out   = addr_q;
    bram_data_out   = data_q;
    bram_we_out     = we_q;
    addr_err_out    = err_q;
    sim_rdata_out   = bram_data_in;
    disp_rdata_out  = bram_data_in;
    sim_rvalid_out  = sim_tag_q[Stages-1];
    disp_rvalid_out = disp_tag_q[Stages-1];
  end

endmodule

// File: tb/tb_lattice_bram_arbiter.sv
// Directed bench for lattice_bram_arbiter; read returns tracked by a scoreboard.
module tb_lattice_bram_arbiter;

  localparam int unsigned AW    = 15;
  localparam int unsigned RL    = 2;
  localparam int unsigned DEPTH = 31570;

  logic                clk_in = 1'b0;
  logic                rst_in = 1'b1;
  logic                sim_req_in, sim_we_in;
  logic [8:0][AW-1:0]  sim_addr_in;
  logic [8:0][7:0]     sim_data_in;
  logic                sim_grant_out, sim_rvalid_out;
  logic [8:0][7:0]     sim_rdata_out;
  logic                disp_req_in;
  logic [AW-1:0]       disp_addr_in;
  logic                disp_grant_out, disp_rvalid_out;
  logic [8:0][7:0]     disp_rdata_out;
  logic [8:0][AW-1:0]  bram_addr_out;
  logic [8:0][7:0]     bram_data_out;
  logic                bram_we_out;
  logic [8:0][7:0]     bram_data_in;
  logic                addr_err_out;

  lattice_bram_arbiter dut (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .sim_req_in      (sim_req_in),
    .sim_we_in       (sim_we_in),
    .sim_addr_in     (sim_addr_in),
    .sim_data_in     (sim_data_in),
    .sim_grant_out   (sim_grant_out),
    .sim_rdata_out   (sim_rdata_out),
    .sim_rvalid_out  (sim_rvalid_out),
    .disp_req_in     (disp_req_in),
    .disp_addr_in    (disp_addr_in),
    .disp_grant_out  (disp_grant_out),
    .disp_rdata_out  (disp_rdata_out),
    .disp_rvalid_out (disp_rvalid_out),
    .bram_addr_out   (bram_addr_out),
    .bram_data_out   (bram_data_out),
    .bram_we_out     (bram_we_out),
    .bram_data_in    (bram_data_in),
    .addr_err_out    (addr_err_out)
  );

  always #5 clk_in = ~clk_in;

  int cyc = 0;
  always @(posedge clk_in) cyc <= cyc + 1;

  function automatic logic [8:0][7:0] pattern(input int c);
    logic [8:0][7:0] p;
    for (int b = 0; b < 9; b++) p[b] = 8'(c * 3 + b * 17);
    return p;
  endfunction

  assign bram_data_in = pattern(cyc);

  typedef struct {
    int due;
    bit is_sim;
  } ret_t;

  ret_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  task automatic chk(input string tag, input logic [143:0] obs, input logic [143:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Return monitor: each cycle either the scoreboard head is due, or no rvalid.
  bit mon_en = 1'b0;
  always @(negedge clk_in) begin
    if (mon_en) begin
      if (sb.size() > 0 && sb[0].due == cyc) begin
        chk("rvalid_sim", 144'(sim_rvalid_out), 144'(sb[0].is_sim));
        chk("rvalid_disp", 144'(disp_rvalid_out), 144'(!sb[0].is_sim));
        if (sb[0].is_sim) chk("sim_rdata", 144'(sim_rdata_out), 144'(pattern(cyc)));
        else chk("disp_rdata", 144'(disp_rdata_out), 144'(pattern(cyc)));
        void'(sb.pop_front());
      end else begin
        chk("no_rvalid", 144'({sim_rvalid_out, disp_rvalid_out}), 144'(2'b00));
      end
    end
  end

  // Expected registered BRAM drive for the cycle after the previous step.
  logic [8:0][AW-1:0] exp_addr;
  logic [8:0][7:0]    exp_data;
  bit                 exp_we, exp_err, pend;

  function automatic logic [8:0][AW-1:0] all_addr(input logic [AW-1:0] a);
    return {9{a}};
  endfunction

  function automatic logic [8:0][7:0] all_data(input logic [7:0] d);
    return {9{d}};
  endfunction

  // One arbitration cycle: drive, check grants and last cycle's BRAM drive,
  // then model this cycle's effect.
  task automatic step(input string tag, input bit sreq, input bit swe,
                      input logic [8:0][AW-1:0] saddr, input logic [8:0][7:0] sdata,
                      input bit dreq, input logic [AW-1:0] daddr,
                      input bit exp_sg, input bit exp_dg);
    bit bad;
    sim_req_in   = sreq;
    sim_we_in    = swe;
    sim_addr_in  = saddr;
    sim_data_in  = sdata;
    disp_req_in  = dreq;
    disp_addr_in = daddr;
    @(negedge clk_in);
    if (pend) begin
      chk($sformatf("%s.prev_we", tag), 144'(bram_we_out), 144'(exp_we));
      chk($sformatf("%s.prev_err", tag), 144'(addr_err_out), 144'(exp_err));
      chk($sformatf("%s.prev_addr", tag), 144'(bram_addr_out), 144'(exp_addr));
      chk($sformatf("%s.prev_data", tag), 144'(bram_data_out), 144'(exp_data));
    end
    chk($sformatf("%s.sim_grant", tag), 144'(sim_grant_out), 144'(exp_sg));
    chk($sformatf("%s.disp_grant", tag), 144'(disp_grant_out), 144'(exp_dg));
    pend    = 1'b1;
    exp_we  = 1'b0;
    exp_err = 1'b0;
    if (exp_sg) begin
      bad = 1'b0;
      for (int b = 0; b < 9; b++) if (32'(saddr[b]) >= DEPTH) bad = 1'b1;
      exp_addr = saddr;
      exp_data = sdata;
      exp_we   = swe && !bad;
      exp_err  = bad;
      if (!swe && !bad) sb.push_back('{due: cyc + 1 + RL, is_sim: 1'b1});
    end else if (exp_dg) begin
      bad      = (32'(daddr) >= DEPTH);
      exp_addr = all_addr(daddr);
      exp_err  = bad;
      if (!bad) sb.push_back('{due: cyc + 1 + RL, is_sim: 1'b0});
    end
    @(posedge clk_in);
    #1;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 0, 0, '0, '0, 0, '0, 0, 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk($sformatf("%s.we", tag), 144'(bram_we_out), 144'(0));
    chk($sformatf("%s.err", tag), 144'(addr_err_out), 144'(0));
    chk($sformatf("%s.rvalids", tag), 144'({sim_rvalid_out, disp_rvalid_out}), 144'(0));
    chk($sformatf("%s.addr", tag), 144'(bram_addr_out), 144'(0));
    chk($sformatf("%s.data", tag), 144'(bram_data_out), 144'(0));
    chk($sformatf("%s.grants", tag), 144'({sim_grant_out, disp_grant_out}), 144'(0));
  endtask

  initial begin
    pend         = 1'b0;
    exp_addr     = '0;
    exp_data     = '0;
    exp_we       = 1'b0;
    exp_err      = 1'b0;
    sim_req_in   = 1'b1;
    sim_we_in    = 1'b0;
    sim_addr_in  = all_addr(15'd3);
    sim_data_in  = all_data(8'h11);
    disp_req_in  = 1'b1;
    disp_addr_in = 15'd4;

    // Reset: both requesting, nothing granted, all outputs clear.
    repeat (2) @(negedge clk_in);
    chk_reset_outputs("reset");
    sim_req_in  = 1'b0;
    disp_req_in = 1'b0;
    @(posedge clk_in);
    #1;
    rst_in = 1'b0;
    mon_en = 1'b1;

    // Sim read at address 5, return three cycles later.
    step("sim_rd5", 1, 0, all_addr(15'd5), all_data(8'h00), 0, '0, 1, 0);
    idle("after_rd5", 3);

    // Sim write 0x0A at address 100: we high, no return.
    step("sim_wr100", 1, 1, all_addr(15'd100), all_data(8'h0A), 0, '0, 1, 0);
    idle("after_wr", 1);

    // Display read out of range: granted, error pulse, no return.
    step("disp_oor", 0, 0, '0, '0, 1, 15'd31570, 0, 1);
    idle("after_door", 1);

    // Sim write with a single bad bank: write suppressed, error pulse.
    begin
      logic [8:0][AW-1:0] a;
      a    = all_addr(15'd50);
      a[3] = 15'd32000;
      step("sim_oor_wr", 1, 1, a, all_data(8'h55), 0, '0, 1, 0);
    end
    idle("after_soor", 1);

    // Alternating sole-requester reads, back to back.
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step($sformatf("alt%0d", i), 1, 0, all_addr(AW'(10 + i)), '0, 0, '0, 1, 0);
      else
        step($sformatf("alt%0d", i), 0, 0, '0, '0, 1, AW'(200 + i), 0, 1);
    end
    idle("after_alt", 4);

    // Continuous contention: display eight times, then one forced sim grant.
    for (int i = 0; i < 18; i++) begin
      step($sformatf("contend%0d", i), 1, 0, all_addr(AW'(300 + i)), '0,
           1, AW'(400 + i), (i % 9 == 8), (i % 9 != 8));
    end
    idle("after_contend", 4);

    // Two granted reads, then reset mid-flight: both returns must vanish.
    step("pre_rst_sim", 1, 0, all_addr(15'd7), '0, 0, '0, 1, 0);
    step("pre_rst_disp", 0, 0, '0, '0, 1, 15'd9, 0, 1);
    sim_req_in  = 1'b1;
    disp_req_in = 1'b1;
    #2;
    rst_in = 1'b1;
    sb.delete();
    pend     = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    #1;
    chk_reset_outputs("mid_reset");
    @(posedge clk_in);
    #1;
    sim_req_in  = 1'b0;
    disp_req_in = 1'b0;
    rst_in      = 1'b0;
    idle("post_reset", 6);

    chk("sb_drained", 144'(sb.size()), 144'(0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
